// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg : branch condition codes, 2-bit counter states, condition eval
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package branch_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLTZ = 3'b011;
  localparam logic [2:0] BR_BGEZ = 3'b100;
  localparam logic [2:0] BR_BLEZ = 3'b101;
  localparam logic [2:0] BR_BGTZ = 3'b110;
  localparam logic [2:0] BR_RSVD = 3'b111;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;
  localparam logic [1:0] CNT_RST = CNT_WNT;

  function automatic logic br_is_branch(input logic [2:0] cond);
    return (cond != BR_NONE) && (cond != BR_RSVD);
  endfunction

  function automatic logic br_taken(input logic [2:0] cond, input logic zero, input logic neg);
    logic t;
    t = 1'b0;
    case (cond)
      BR_BEQ:  t = zero;
      BR_BNE:  t = !zero;
      BR_BLTZ: t = neg;
      BR_BGEZ: t = !neg;
      BR_BLEZ: t = neg | zero;
      BR_BGTZ: t = !neg & !zero;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolve_unit_sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2 : 2-bit saturating up/down counter, resets to weak-not-taken
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter2
  import branch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  output logic [1:0] q
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (up && (cnt_q != CNT_ST)) begin
        cnt_d = cnt_q + 2'd1;
      end else if (!up && (cnt_q != CNT_SNT)) begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= CNT_RST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit : EX-stage branch resolution, bimodal predictor table,
//                       registered redirect/flush and saturating mispredict count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BHT_DEPTH = 16,
  parameter int PERF_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [2:0]        ex_cond,
  input  logic              ex_zero,
  input  logic              ex_neg,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  output logic              pcsrc,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic [PERF_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0]  lookup_idx;
  logic [IDX_W-1:0]  update_idx;
  logic [1:0]        bht_cnt [BHT_DEPTH];
  logic              resolve;
  logic              taken;
  logic              mispredict;

  logic              pcsrc_q, pcsrc_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [PERF_W-1:0] mp_cnt_q, mp_cnt_d;

  // Word-aligned PCs: table index starts at bit 2.
  assign lookup_idx = IDX_W'(if_pc >> 2);
  assign update_idx = IDX_W'(ex_pc >> 2);

  assign resolve    = ex_valid && br_is_branch(ex_cond);
  assign taken      = br_taken(ex_cond, ex_zero, ex_neg);
  assign mispredict = resolve && (taken != ex_pred_taken);

  for (genvar i = 0; i < BHT_DEPTH; i++) begin : g_bht
    sat_counter2 u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (resolve && (update_idx == IDX_W'(i))),
      .up    (taken),
      .q     (bht_cnt[i])
    );
  end

  // Lookup sees the pre-edge counter; no bypass from a same-cycle update.
  assign if_pred_taken = bht_cnt[lookup_idx][1];

  always_comb begin
    pcsrc_d          = pcsrc_q;
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    mp_cnt_d         = mp_cnt_q;
    if (resolve) begin
      pcsrc_d = taken;
    end
    if (mispredict) begin
      redirect_pc_d = taken ? ex_target : (ex_pc + ADDR_W'(4));
      if (mp_cnt_q != {PERF_W{1'b1}}) begin
        mp_cnt_d = mp_cnt_q + PERF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcsrc_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mp_cnt_q         <= '0;
    end else begin
      pcsrc_q          <= pcsrc_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mp_cnt_q         <= mp_cnt_d;
    end
  end

  assign pcsrc          = pcsrc_q;
  assign redirect_valid = redirect_valid_q;
  assign flush          = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign mispredict_cnt = mp_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit : directed + random bench against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_resolve_unit;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int PERF_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] if_pc;
  logic              if_pred_taken;
  logic              ex_valid;
  logic [2:0]        ex_cond;
  logic              ex_zero;
  logic              ex_neg;
  logic [ADDR_W-1:0] ex_pc;
  logic [ADDR_W-1:0] ex_target;
  logic              ex_pred_taken;
  logic              pcsrc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush;
  logic [PERF_W-1:0] mispredict_cnt;

  branch_resolve_unit #(.ADDR_W(ADDR_W), .BHT_DEPTH(DEPTH), .PERF_W(PERF_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_cond        (ex_cond),
    .ex_zero        (ex_zero),
    .ex_neg         (ex_neg),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .pcsrc          (pcsrc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state
  int          m_bht [DEPTH];
  bit          m_pcsrc;
  bit          m_rv;
  logic [31:0] m_rpc;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input int c, input bit z, input bit n);
    case (c)
      1:       return z;
      2:       return !z;
      3:       return n;
      4:       return !n;
      5:       return n || z;
      6:       return !n && !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int pc_idx(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    m_pcsrc = 0; m_rv = 0; m_rpc = 0; m_cnt = 0;
  endtask

  // One clock: drive, check prediction pre-edge, advance model, check registered outputs.
  task automatic step(input bit rn, input bit v, input int c, input bit z, input bit n,
                      input logic [31:0] pc, input logic [31:0] tgt, input bit pt,
                      input logic [31:0] ipc);
    bit t;
    int k;
    rst_n = rn; ex_valid = v; ex_cond = 3'(c); ex_zero = z; ex_neg = n;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; if_pc = ipc;
    #1;
    chk("pred", {31'd0, if_pred_taken}, {31'd0, m_bht[pc_idx(ipc)] >= 2});
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else if (v && c >= 1 && c <= 6) begin
      t = ref_taken(c, z, n);
      k = pc_idx(pc);
      m_pcsrc = t;
      m_bht[k] = t ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3) : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
      m_rv = (t != pt);
      if (m_rv) begin
        m_rpc = t ? tgt : pc + 32'd4;
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      end
    end else begin
      m_rv = 0;
    end
    #1;
    chk("pcsrc",  {31'd0, pcsrc},          {31'd0, m_pcsrc});
    chk("rvalid", {31'd0, redirect_valid}, {31'd0, m_rv});
    chk("flush",  {31'd0, flush},          {31'd0, m_rv});
    chk("rpc",    redirect_pc,             m_rpc);
    chk("mpcnt",  {28'd0, mispredict_cnt}, 32'(m_cnt));
  endtask

  task automatic peek_pred(input string tag, input logic [31:0] ipc, input bit exp);
    if_pc = ipc;
    #1;
    chk(tag, {31'd0, if_pred_taken}, {31'd0, exp});
  endtask

  logic [31:0] rpc, rtgt, ripc;
  int          rc;

  initial begin
    rst_n = 0; ex_valid = 0; ex_cond = 0; ex_zero = 0; ex_neg = 0;
    ex_pc = 0; ex_target = 0; ex_pred_taken = 0; if_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state and table sweep
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 32'(i * 4));
    chk("rst_pcsrc", {31'd0, pcsrc}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_cnt", {28'd0, mispredict_cnt}, 32'd0);

    // Taken BEQs at 0x40, predicted not-taken
    step(1, 1, 1, 1, 0, 32'h40, 32'h80, 0, 32'h40);
    chk("beq_rpc", redirect_pc, 32'h80);
    chk("beq_flush", {31'd0, flush}, 32'd1);
    chk("beq_cnt", {28'd0, mispredict_cnt}, 32'd1);
    step(1, 1, 1, 1, 0, 32'h40, 32'h80, 0, 32'h40);
    peek_pred("pred_after2", 32'h40, 1);
    repeat (3) step(1, 1, 1, 1, 0, 32'h40, 32'h80, 0, 32'h40);
    step(1, 1, 1, 0, 0, 32'h40, 32'h80, 1, 32'h40);
    peek_pred("sat_then_dec", 32'h40, 1);

    // Every code against zero/neg in {00,01,10}
    for (int c = 0; c < 8; c++) begin
      for (int zn = 0; zn < 3; zn++) begin
        step(1, 1, c, zn[1], zn[0], 32'($urandom) & 32'hFFFF_FFFC, $urandom, 1'($urandom), $urandom);
        if (c == 5 && zn == 2) chk("blez_z", {31'd0, pcsrc}, 32'd1);
        if (c == 6 && zn == 0) chk("bgtz_00", {31'd0, pcsrc}, 32'd1);
      end
    end

    // Not-taken mispredict wrapping past the top of the address space
    step(1, 1, 2, 1, 0, 32'hFFFF_FFFC, 32'h1234, 1, 0);
    chk("wrap_rpc", redirect_pc, 32'h0000_0000);
    chk("wrap_rv", {31'd0, redirect_valid}, 32'd1);

    // Same-index lookup and update: lookup sees old value (checked in step)
    step(1, 1, 1, 1, 0, 32'h104, 32'h200, 0, 32'h204);
    step(1, 1, 1, 1, 0, 32'h104, 32'h200, 0, 32'h304);
    peek_pred("conflict_after", 32'h104, 1);

    // Count saturation
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 1, 0, 32'(i * 4), 32'(i * 8), 0, 32'(i * 4));
    chk("cnt_sat", {28'd0, mispredict_cnt}, 32'd15);

    // Reset coincident with a mispredicting resolve
    step(1, 1, 1, 1, 0, 32'h40, 32'h80, 0, 32'h40);
    step(0, 1, 1, 1, 0, 32'h40, 32'h80, 0, 32'h40);
    chk("rst_mid_rv", {31'd0, redirect_valid}, 32'd0);
    peek_pred("rst_mid_pred", 32'h40, 0);
    step(1, 1, 1, 1, 0, 32'h40, 32'h80, 0, 32'h40);
    peek_pred("rst_mid_cnt01", 32'h40, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rpc  = {26'd0, 4'($urandom_range(0, 15)), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 : 32'd0);
      rtgt = $urandom;
      ripc = {26'($urandom), 4'($urandom_range(0, 15)), 2'($urandom)};
      rc   = $urandom_range(0, 7);
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0), rc, 1'($urandom), 1'($urandom),
           rpc, rtgt, 1'($urandom), ripc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised successor to the single-cycle beq/bne PCSrc logic. Sits at the EX stage of the pipelined MIPS core: resolves six branch conditions, keeps a direct-mapped table of 2-bit saturating counters queried by IF, and issues a registered redirect/flush on misprediction. It also keeps a saturating mispredict count for performance monitoring.

## Interface

**Parameters**
- `ADDR_W`, 32: PC and target width.
- `BHT_DEPTH`, 16: counter-table entries; power of two, 2..64.
- `PERF_W`, 16: mispredict counter width.

**Ports** (`IDX_W` = log2(`BHT_DEPTH`))
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `if_pc` in ADDR_W: fetch PC for prediction lookup.
- `if_pred_taken` out 1: combinational prediction for `if_pc`.
- `ex_valid` in 1: EX slot holds a valid instruction.
- `ex_cond` in 3: branch condition code.
- `ex_zero` in 1: ALU zero. For BEQ/BNE this is rs−rt==0; otherwise rs==0.
- `ex_neg` in 1: rs[31].
- `ex_pc` in ADDR_W: branch PC.
- `ex_target` in ADDR_W: computed branch target.
- `ex_pred_taken` in 1: prediction carried down the pipe from IF.
- `pcsrc` out 1: registered actual-taken result of the last resolved branch.
- `redirect_valid` out 1: registered 1-cycle pulse on mispredict.
- `redirect_pc` out ADDR_W: registered correct next PC.
- `flush` out 1: registered; equals `redirect_valid`.
- `mispredict_cnt` out PERF_W: saturating mispredict count.

## Operation

**Condition codes**
- 000: NONE
- 001: BEQ, zero
- 010: BNE, !zero
- 011: BLTZ, neg
- 100: BGEZ, !neg
- 101: BLEZ, neg|zero
- 110: BGTZ, !neg&!zero
- 111: reserved; treated as NONE

**Resolve event**
- A resolve event occurs when `ex_valid` is 1 and `ex_cond` is a branch code (001..110).
- `taken` is the condition result. `mispredict` = `taken` != `ex_pred_taken`.

**Prediction lookup**
- Index = `if_pc[IDX_W+1:2]`.
- `if_pred_taken` = MSB of the indexed counter.

**Counter update**
- On a resolve event, the counter at index `ex_pc[IDX_W+1:2]` updates with saturation.
- Taken: increment, saturating at 11.
- Not taken: decrement, saturating at 00.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

**Redirect**
- On a mispredict, the next edge sets `redirect_valid`=1 and `flush`=1.
- `redirect_pc` = `ex_target` if taken, else `ex_pc`+4, with modulo 2^ADDR_W wrap.
- Otherwise the next edge sets `redirect_valid`=0 and `flush`=0; `redirect_pc` holds its value.

**pcsrc**
- Updated to `taken` on every resolve event.
- Holds its value when there is no resolve event.

**mispredict_cnt**
- +1 per mispredict; saturates at all-ones and does not wrap.

**Non-branch cycles**
- `ex_valid`=0 or NONE/reserved code: no table update, no redirect, no count.

## Timing

- **Reset** (`rst_n`=0 at an edge):
  - All counters go to 01.
  - `pcsrc`, `redirect_valid`, `flush` go to 0; `redirect_pc` and `mispredict_cnt` go to 0.
  - Any resolve in the same cycle is discarded.
  - Reset asserted mid-burst cancels a pending redirect.
- **Prediction:** zero latency, combinational from `if_pc`.
- **Resolution to redirect/flush/pcsrc:** 1 cycle.
- **Counter update:** visible to lookup on the cycle after the resolve edge.
- **Same-index lookup and update in one cycle:** lookup returns the pre-update value; no bypass.
- **Back-to-back mispredicts:** `redirect_valid` stays high on consecutive cycles, and each cycle carries its own `redirect_pc`.
- **Bubble:** the core must drive `ex_valid`=0 for the flushed slot. The unit does not self-mask.

## Structure

- Shared package `branch_pkg` holds:
  - `ex_cond` localparams: `BR_NONE`, `BR_BEQ` … `BR_BGTZ`.
  - Counter state constants: `CNT_SNT`, `CNT_WNT`, `CNT_WT`, `CNT_ST`; reset value `CNT_WNT`.
  - Function `br_taken(cond, zero, neg)`.
- One sub-module, `sat_counter2`: a 2-bit saturating counter with `clk`, `rst_n`, `en`, `up`, `q`, instantiated `BHT_DEPTH` times via generate.
- Top level holds the condition decode, index/update logic, redirect registers and perf counter.

## Test plan

1. **Reset, then lookup with no updates:** after `rst_n` low for 1 cycle, every `if_pc` gives `if_pred_taken`=0 and all outputs are 0.
2. **Four taken BEQs at one PC:** `ex_pc`=0x40, `ex_zero`=1, `ex_pred_taken`=0, `ex_target`=0x80.
   - Cycle+1 of the first gives `redirect_pc`=0x80, `flush`=1, `mispredict_cnt`=1.
   - After the 2nd update, lookup at 0x40 gives 1.
   - The counter saturates at 11; a 5th taken resolve leaves it at 11.
3. **All six codes:** sweep `zero`/`neg` ∈ {00, 01, 10} for each code; `pcsrc` matches the truth table.
   - BLEZ with zero=1: taken.
   - BGTZ with zero=0, neg=0: taken.
   - Reserved code 111: no change to any state.
4. **Not-taken mispredict with wrap:** `ex_pc`=0xFFFF_FFFC, `ex_pred_taken`=1, BNE with zero=1 → `redirect_pc`=0x0000_0000.
5. **Same-cycle conflict and saturation:**
   - `if_pc` and `ex_pc` at the same index in one cycle: the lookup returns the old value.
   - With `PERF_W`=4, 20 mispredicts leave `mispredict_cnt`=15.
6. **Reset mid-operation:** assert `rst_n`=0 in the same cycle as a mispredicting resolve → no redirect next cycle and the counter stays at 01.
